// File: rtl/simplez_core.sv
`default_nettype none
// ============================================================================
// Module   : simplez_core
// Brief    : Parametrised multi-cycle Simplez CPU on a 1-cycle-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
module simplez_core #(
    parameter int AW         = 9,
    parameter int DW         = 12,
    parameter int WAIT_DELAY = 2400000,
    parameter int IO_ADDR    = 2**AW - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_port,
    output logic          halted,
    output logic          wait_busy,
    output logic          retire
);

    localparam int CW = (WAIT_DELAY > 1) ? $clog2(WAIT_DELAY) : 1;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WAIT   = 3'd4;
    localparam state_t S_HALTED = 3'd5;

    localparam logic [2:0] c_OP_ST  = 3'd0;
    localparam logic [2:0] c_OP_LD  = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_BR  = 3'd3;
    localparam logic [2:0] c_OP_BZ  = 3'd4;
    localparam logic [2:0] c_OP_CLR = 3'd5;
    localparam logic [2:0] c_OP_DEC = 3'd6;

    localparam logic [CW-1:0] c_WAIT_LOAD = CW'(WAIT_DELAY - 1);
    localparam logic [AW-1:0] c_IO_ADDR   = AW'(IO_ADDR);

    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_pc, w_pc_nx;
    logic [DW-1:0] r_acc, w_acc_nx;
    logic [DW-1:0] r_ri, w_ri_nx;
    logic [DW-1:0] r_out, w_out_nx;
    logic          r_halted, w_halted_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;

    logic [2:0]    w_co;
    logic [AW-1:0] w_cd;
    logic          w_is_wait;
    logic [AW-1:0] w_mem_addr;
    logic          w_we;
    logic          w_retire;

    assign w_co      = r_ri[DW-1:DW-3];
    assign w_cd      = r_ri[AW-1:0];
    // Extended opcodes differ only in the lowest COE bit: E = HALT, F = WAIT.
    assign w_is_wait = r_ri[DW-4];

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_acc_nx    = r_acc;
        w_ri_nx     = r_ri;
        w_out_nx    = r_out;
        w_halted_nx = r_halted;
        w_cnt_nx    = r_cnt;
        w_mem_addr  = w_cd;
        w_we        = 1'b0;
        w_retire    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_addr = r_pc;
                if (run) begin
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                w_mem_addr = r_pc;
                w_ri_nx    = mem_rdata;
                w_pc_nx    = r_pc + AW'(1);
                w_state_nx = S_EXEC;
            end
            S_EXEC: begin
                w_state_nx = S_FETCH;
                case (w_co)
                    c_OP_ST: begin
                        w_we     = 1'b1;
                        w_retire = 1'b1;
                        if (w_cd == c_IO_ADDR) begin
                            w_out_nx = r_acc;
                        end
                    end
                    c_OP_LD, c_OP_ADD: begin
                        w_state_nx = S_MEM;
                    end
                    c_OP_BR: begin
                        w_pc_nx  = w_cd;
                        w_retire = 1'b1;
                    end
                    c_OP_BZ: begin
                        if (r_acc == '0) begin
                            w_pc_nx = w_cd;
                        end
                        w_retire = 1'b1;
                    end
                    c_OP_CLR: begin
                        w_acc_nx = '0;
                        w_retire = 1'b1;
                    end
                    c_OP_DEC: begin
                        w_acc_nx = r_acc - DW'(1);
                        w_retire = 1'b1;
                    end
                    default: begin
                        if (w_is_wait) begin
                            w_cnt_nx   = c_WAIT_LOAD;
                            w_state_nx = S_WAIT;
                        end else begin
                            w_halted_nx = 1'b1;
                            w_retire    = 1'b1;
                            w_state_nx  = S_HALTED;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (w_co == c_OP_LD) begin
                    w_acc_nx = mem_rdata;
                end else begin
                    w_acc_nx = r_acc + mem_rdata;
                end
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_retire   = 1'b1;
                    w_state_nx = S_FETCH;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_HALTED: begin
                w_state_nx = S_HALTED;
            end
            default: begin
                w_state_nx = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_acc    <= '0;
            r_ri     <= '0;
            r_out    <= '0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_acc    <= w_acc_nx;
            r_ri     <= w_ri_nx;
            r_out    <= w_out_nx;
            r_halted <= w_halted_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    // Gating with rst keeps an aborted ST from reaching the RAM.
    assign mem_we    = w_we & ~rst;
    assign retire    = w_retire & ~rst;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = r_acc;
    assign out_port  = r_out;
    assign halted    = r_halted;
    assign wait_busy = (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_simplez_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_simplez_core
// Brief    : Directed self-checking bench for simplez_core with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simplez_core;

    logic        clk;
    logic        rst;
    logic        run;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] out_port;
    logic        halted;
    logic        wait_busy;
    logic        retire;

    logic [11:0] r_mem [0:511];
    logic        r_ld_clr;
    logic        r_ld_we;
    logic [8:0]  r_ld_addr;
    logic [11:0] r_ld_data;

    int checks;
    int errors;

    simplez_core #(
        .AW         (9),
        .DW         (12),
        .WAIT_DELAY (10),
        .IO_ADDR    (511)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_port  (out_port),
        .halted    (halted),
        .wait_busy (wait_busy),
        .retire    (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with a bench-side load port used only while the core is in reset.
    always @(posedge clk) begin
        if (r_ld_clr) begin
            for (int i = 0; i < 512; i++) r_mem[i] <= '0;
        end else if (r_ld_we) begin
            r_mem[r_ld_addr] <= r_ld_data;
        end else if (mem_we) begin
            r_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= r_mem[mem_addr];
    end

    task automatic poke(input logic [8:0] a, input logic [11:0] d);
        r_ld_we   = 1'b1;
        r_ld_addr = a;
        r_ld_data = d;
        @(negedge clk);
        r_ld_we   = 1'b0;
    endtask

    task automatic begin_load();
        rst      = 1'b1;
        r_ld_clr = 1'b1;
        @(negedge clk);
        r_ld_clr = 1'b0;
    endtask

    task automatic test_reset();
        begin_load();
        rst = 1'b0;
        checks++;
        if (mem_addr !== 9'd0 || mem_we !== 1'b0 || out_port !== 12'd0 ||
            halted !== 1'b0 || wait_busy !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h we=%b out=%h halt=%b busy=%b ret=%b want all 0",
                     mem_addr, mem_we, out_port, halted, wait_busy, retire);
        end
    endtask

    task automatic test_program1();
        int n_ret = 0;
        begin_load();
        poke(9'o000, 12'o1144);
        poke(9'o001, 12'o2145);
        poke(9'o002, 12'o0146);
        poke(9'o003, 12'o7000);
        poke(9'o144, 12'd5);
        poke(9'o145, 12'd3);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (retire) n_ret++;
            if (i == 13) begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++;
                    $display("FAIL p1_halted_early got %b want 0", halted);
                end
            end
            if (i == 14) begin
                checks++;
                if (halted !== 1'b1) begin
                    errors++;
                    $display("FAIL p1_halted_rise got %b want 1", halted);
                end
            end
        end
        checks++;
        if (r_mem[9'o146] !== 12'd8) begin
            errors++;
            $display("FAIL p1_mem102 got %h want 008", r_mem[9'o146]);
        end
        checks++;
        if (dut.r_acc !== 12'd8) begin
            errors++;
            $display("FAIL p1_acc got %h want 008", dut.r_acc);
        end
        checks++;
        if (n_ret != 4) begin
            errors++;
            $display("FAIL p1_retire_count got %0d want 4", n_ret);
        end
    endtask

    task automatic test_dec_bz();
        begin_load();
        poke(9'o000, 12'o6000);
        poke(9'o001, 12'o4010);
        poke(9'o002, 12'o5000);
        poke(9'o003, 12'o4010);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++;
                if (dut.r_acc !== 12'o7777) begin
                    errors++;
                    $display("FAIL dec_wrap got %o want 7777", dut.r_acc);
                end
            end
            if (i == 6) begin
                checks++;
                if (dut.r_pc !== 9'd2) begin
                    errors++;
                    $display("FAIL bz_not_taken pc got %o want 2", dut.r_pc);
                end
            end
            if (i == 9) begin
                checks++;
                if (dut.r_acc !== 12'd0) begin
                    errors++;
                    $display("FAIL clr got %o want 0", dut.r_acc);
                end
            end
            if (i == 12) begin
                checks++;
                if (dut.r_pc !== 9'o010 || mem_addr !== 9'o010) begin
                    errors++;
                    $display("FAIL bz_taken pc got %o addr %o want 010", dut.r_pc, mem_addr);
                end
            end
        end
    endtask

    task automatic test_io_store();
        begin_load();
        poke(9'o000, 12'o1100);
        poke(9'o001, 12'o0777);
        poke(9'o002, 12'o6000);
        poke(9'o003, 12'o0776);
        poke(9'o004, 12'o7000);
        poke(9'o100, 12'h0A5);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 9'd511 || mem_wdata !== 12'h0A5 || out_port !== 12'h000) begin
            errors++;
            $display("FAIL io_exec got we=%b addr=%h wd=%h out=%h want 1 1ff 0a5 000",
                     mem_we, mem_addr, mem_wdata, out_port);
        end
        @(negedge clk);
        checks++;
        if (out_port !== 12'h0A5 || r_mem[511] !== 12'h0A5) begin
            errors++;
            $display("FAIL io_store got out=%h mem511=%h want 0a5 0a5", out_port, r_mem[511]);
        end
        repeat (13) @(negedge clk);
        checks++;
        if (r_mem[510] !== 12'h0A4 || out_port !== 12'h0A5) begin
            errors++;
            $display("FAIL non_io_store got mem510=%h out=%h want 0a4 0a5", r_mem[510], out_port);
        end
    endtask

    task automatic test_wait();
        int n_busy  = 0;
        int first_i = 0;
        int last_i  = 0;
        begin_load();
        poke(9'o000, 12'o7400);
        poke(9'o001, 12'o7000);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wait_busy === 1'b1) begin
                n_busy++;
                if (first_i == 0) first_i = i;
                last_i = i;
            end
            if (i == 12) begin
                checks++;
                if (retire !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_retire got %b want 1", retire);
                end
            end
            if (i == 13) begin
                checks++;
                if (mem_addr !== 9'd1 || wait_busy !== 1'b0 || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_next_fetch got addr=%h busy=%b halt=%b want 001 0 0",
                             mem_addr, wait_busy, halted);
                end
            end
        end
        checks++;
        if (n_busy != 10 || first_i != 3 || last_i != 12) begin
            errors++;
            $display("FAIL wait_busy_span got n=%0d first=%0d last=%0d want 10 3 12",
                     n_busy, first_i, last_i);
        end
    endtask

    task automatic test_reset_mid_store();
        begin_load();
        poke(9'o000, 12'o1100);
        poke(9'o001, 12'o0200);
        poke(9'o100, 12'd3);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup mem_we got %b want 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL abort_gate got we=%b ret=%b want 0 0", mem_we, retire);
        end
        @(negedge clk);
        checks++;
        if (r_mem[9'o200] !== 12'd0 || dut.r_pc !== 9'd0 || dut.r_acc !== 12'd0 ||
            dut.r_ri !== 12'd0 || out_port !== 12'd0 || halted !== 1'b0 || mem_addr !== 9'd0) begin
            errors++;
            $display("FAIL abort_state got mem=%h pc=%h a=%h ri=%h out=%h halt=%b want all 0",
                     r_mem[9'o200], dut.r_pc, dut.r_acc, dut.r_ri, out_port, halted);
        end
    endtask

    task automatic test_run_hold();
        logic bad = 1'b0;
        begin_load();
        run = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_addr !== 9'd0 || dut.r_pc !== 9'd0 || mem_we !== 1'b0 || retire !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL run_hold got movement with run=0 addr=%h pc=%h want 0", mem_addr, dut.r_pc);
        end
        run = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.r_pc !== 9'd1) begin
            errors++;
            $display("FAIL run_resume pc got %h want 001", dut.r_pc);
        end
    endtask

    task automatic test_pc_wrap();
        int n_ret = 0;
        begin_load();
        poke(9'o000, 12'o3777);
        poke(9'o777, 12'o5000);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (retire) n_ret++;
            if (i == 3) begin
                checks++;
                if (dut.r_pc !== 9'd511 || mem_addr !== 9'd511) begin
                    errors++;
                    $display("FAIL br_511 got pc=%h addr=%h want 1ff", dut.r_pc, mem_addr);
                end
            end
        end
        checks++;
        if (dut.r_pc !== 9'd0 || mem_addr !== 9'd0 || n_ret != 2) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h addr=%h retires=%0d want 0 0 2", dut.r_pc, mem_addr, n_ret);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        run       = 1'b1;
        r_ld_clr  = 1'b0;
        r_ld_we   = 1'b0;
        r_ld_addr = '0;
        r_ld_data = '0;
        @(negedge clk);
        test_reset();
        test_program1();
        test_dec_bz();
        test_io_store();
        test_wait();
        test_reset_mid_store();
        test_run_hold();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
